uart_bip_link: RTL and testbench

- Sits on the processor side of the UART top, between the UART byte interface and the basic instruction processor (BIP).
- Accepts a start command byte from the UART receiver, runs the BIP until it halts, and captures a result snapshot.
- Serialises the snapshot as an 8-byte frame through the UART transmitter, using the `tx_start`/`tx_done` handshake.

---
 rtl/uart_bip_pkg.sv | 21 ++
 rtl/link_frame_snapshot.sv | 54 +++++
 rtl/uart_bip_link.sv | 121 ++++++++++++
 tb/tb_uart_bip_link.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bip_pkg.sv
// Shared definitions for the UART <-> BIP link: FSM encoding, frame geometry
// and parameter defaults.
package uart_bip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } link_state_e;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned FRAME_W   = FRAME_LEN * 8;

    localparam logic [7:0]  CMD_START_DEF = 8'h53;
    localparam int unsigned ACC_W_DEF     = 16;
    localparam int unsigned PC_W_DEF      = 11;
    localparam int unsigned CNT_W_DEF     = 32;

endpackage

// File: rtl/link_frame_snapshot.sv
// Result snapshot register plus the frame byte select.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   capture          load {acc, pc, count} into the snapshot this edge
//   acc, pc, count   live BIP values
//   idx_next         byte index that will be current after this edge
//   byte_out         registered frame byte for the current index
module link_frame_snapshot
    import uart_bip_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [ACC_W-1:0] acc,
    input  logic [PC_W-1:0]  pc,
    input  logic [CNT_W-1:0] count,
    input  logic [IDX_W-1:0] idx_next,
    output logic [7:0]       byte_out
);

    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;
    logic [FRAME_W-1:0] frame_shift;
    logic [7:0]         byte_q;
    logic [7:0]         byte_d;

    // Byte is selected from next-state values so the registered output
    // always equals frame[idx] of the current snapshot.
    always_comb begin
        frame_d = frame_q;
        if (capture) begin
            frame_d = {16'(acc), 16'(pc), 32'(count)};
        end
        frame_shift = frame_d << {idx_next, 3'b000};
        byte_d      = frame_shift[FRAME_W-1 -: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            byte_q  <= '0;
        end else begin
            frame_q <= frame_d;
            byte_q  <= byte_d;
        end
    end

    assign byte_out = byte_q;

endmodule

// File: rtl/uart_bip_link.sv
// Processor-side glue between the UART byte interface and the BIP: a start
// command launches a BIP run, the halt result is snapshotted and sent back
// as an 8-byte frame (acc, pc, cycle count; MSB first).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   rx_done, uart_to_bip        received byte strobe and data
//   tx_done                     transmitter finished current byte
//   tx_start, bip_to_uart       transmit strobe and byte (stable until tx_done)
//   bip_halt, bip_acc, bip_pc,
//   bip_clk_count               BIP status inputs
//   bip_enable                  BIP run enable
//   busy                        high whenever not idle
module uart_bip_link
    import uart_bip_pkg::*;
#(
    parameter logic [7:0]  CMD_START = CMD_START_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done,
    input  logic [7:0]       uart_to_bip,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       bip_to_uart,
    input  logic             bip_halt,
    input  logic [ACC_W-1:0] bip_acc,
    input  logic [PC_W-1:0]  bip_pc,
    input  logic [CNT_W-1:0] bip_clk_count,
    output logic             bip_enable,
    output logic             busy
);

    link_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tx_start_q, tx_start_d;
    logic             bip_enable_q, bip_enable_d;
    logic             busy_q, busy_d;
    logic             capture_c;

    // Next-state, index and registered-output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_done && (uart_to_bip == CMD_START)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bip_halt) begin
                    capture_c = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are flop-driven
        tx_start_d   = (state_d == ST_SEND);
        bip_enable_d = (state_d == ST_RUN);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tx_start_q   <= 1'b0;
            bip_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tx_start_q   <= tx_start_d;
            bip_enable_q <= bip_enable_d;
            busy_q       <= busy_d;
        end
    end

    link_frame_snapshot #(
        .ACC_W (ACC_W),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) u_snapshot (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture_c),
        .acc      (bip_acc),
        .pc       (bip_pc),
        .count    (bip_clk_count),
        .idx_next (idx_d),
        .byte_out (bip_to_uart)
    );

    assign tx_start   = tx_start_q;
    assign bip_enable = bip_enable_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_bip_link.sv
// Scoreboard bench for uart_bip_link: stimulus pushes hand-computed frame
// bytes, a monitor pops and compares on every tx_start.
module tb_uart_bip_link;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  uart_to_bip = 8'h00;
    logic        tx_done;
    logic        tx_done_model = 1'b0;
    logic        tx_done_spur = 1'b0;
    logic        tx_start;
    logic [7:0]  bip_to_uart;
    logic        bip_halt = 1'b0;
    logic [15:0] bip_acc = 16'h0000;
    logic [10:0] bip_pc = 11'h000;
    logic [31:0] bip_clk_count = 32'h0;
    logic        bip_enable;
    logic        busy;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned tx_count = 0;
    int unsigned last_done_cyc = 0;
    logic [7:0]  exp_q[$];

    assign tx_done = tx_done_model | tx_done_spur;

    uart_bip_link dut (
        .clk           (clk),
        .reset         (reset),
        .rx_done       (rx_done),
        .uart_to_bip   (uart_to_bip),
        .tx_done       (tx_done),
        .tx_start      (tx_start),
        .bip_to_uart   (bip_to_uart),
        .bip_halt      (bip_halt),
        .bip_acc       (bip_acc),
        .bip_pc        (bip_pc),
        .bip_clk_count (bip_clk_count),
        .bip_enable    (bip_enable),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Push 8 frame bytes given as one hand-written 64-bit word, MSB first
    task automatic push_frame(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) exp_q.push_back(bytes[63 - 8*i -: 8]);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_done     = 1'b1;
        uart_to_bip = b;
        @(negedge clk);
        rx_done     = 1'b0;
    endtask

    task automatic halt_pulse();
        bip_halt = 1'b1;
        @(negedge clk);
        bip_halt = 1'b0;
    endtask

    task automatic wait_busy_low(output int unsigned fall);
        int i = 0;
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("frame_completes", 64'(busy), 64'd0);
        fall = cyc;
    endtask

    task automatic wait_tx(input int unsigned target);
        int i = 0;
        while (tx_count < target && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("tx_start_reached", 64'(tx_count >= target), 64'd1);
    endtask

    // Transmitter model: tx_done 10 cycles after each tx_start
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            tx_done_model = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done_model = 1'b1;
            end else if (tx_start) begin
                cnt = 10;
            end
        end
    end

    // Monitor: compare each transmitted byte and its stability
    initial begin
        logic [7:0] held_b = 8'h00;
        bit         in_byte = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) in_byte = 1'b0;
            if (tx_done) begin
                last_done_cyc = cyc;
                if (in_byte && busy) chk("byte_stable", 64'(bip_to_uart), 64'(held_b));
                in_byte = 1'b0;
            end
            if (tx_start) begin
                tx_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_start", 64'(bip_to_uart), 64'hFFFF);
                end else begin
                    chk("frame_byte", 64'(bip_to_uart), 64'(exp_q.pop_front()));
                end
                held_b  = bip_to_uart;
                in_byte = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned fall;

        // Reset held with CMD_START pulses: everything stays 0
        uart_to_bip = 8'h53;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_done = (i % 2 == 0);
            chk("reset_outputs_zero", 64'({tx_start, bip_to_uart, bip_enable, busy}), 64'd0);
        end
        @(negedge clk);
        rx_done = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

        // Non-command byte in IDLE is ignored
        send_rx(8'h41);
        chk("ignore_41_enable", 64'(bip_enable), 64'd0);
        @(negedge clk);
        chk("ignore_41_busy", 64'(busy), 64'd0);

        // Main frame: BEEF / 7A5 / 0001_2345
        bip_acc = 16'hBEEF; bip_pc = 11'h7A5; bip_clk_count = 32'h0001_2345;
        base = tx_count;
        send_rx(8'h53);
        chk("run_enable", 64'(bip_enable), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("run_holds_without_halt", 64'({bip_enable, tx_start}), 64'b10);
        push_frame(64'hBEEF_07A5_0001_2345);
        halt_pulse();
        chk("first_tx_start", 64'(tx_start), 64'd1);
        chk("enable_drops_on_capture", 64'(bip_enable), 64'd0);
        wait_busy_low(fall);
        chk("busy_fall_latency", 64'(fall), 64'(last_done_cyc + 1));
        chk("frame1_len", 64'(tx_count - base), 64'd8);
        chk("frame1_drained", 64'(exp_q.size()), 64'd0);

        // Spurious tx_done in RUN and CMD_START mid-frame are ignored
        bip_acc = 16'h1234; bip_pc = 11'h001; bip_clk_count = 32'hDEAD_BEEF;
        base = tx_count;
        send_rx(8'h53);
        tx_done_spur = 1'b1;
        @(negedge clk);
        tx_done_spur = 1'b0;
        @(negedge clk);
        chk("spur_done_in_run", 64'({bip_enable, busy, tx_start}), 64'b110);
        push_frame(64'h1234_0001_DEAD_BEEF);
        halt_pulse();
        wait_tx(base + 4);
        repeat (3) @(negedge clk);
        send_rx(8'h53);
        wait_busy_low(fall);
        chk("frame2_len", 64'(tx_count - base), 64'd8);
        repeat (20) @(negedge clk);
        chk("no_restart_busy", 64'({busy, bip_enable}), 64'd0);
        chk("no_extra_tx_start", 64'(tx_count - base), 64'd8);

        // Halt already high at RUN entry: one-cycle enable, capture then
        bip_acc = 16'h00FF; bip_pc = 11'h000; bip_clk_count = 32'h0;
        bip_halt = 1'b1;
        base = tx_count;
        push_frame(64'hA5C3_0123_CAFE_F00D);
        send_rx(8'h53);
        chk("pre_halt_enable", 64'(bip_enable), 64'd1);
        bip_acc = 16'hA5C3; bip_pc = 11'h123; bip_clk_count = 32'hCAFE_F00D;
        @(negedge clk);
        chk("pre_halt_enable_one_cycle", 64'(bip_enable), 64'd0);
        chk("pre_halt_tx_start", 64'(tx_start), 64'd1);
        bip_acc = 16'hFFFF; bip_pc = 11'h7FF; bip_clk_count = 32'hFFFF_FFFF;
        bip_halt = 1'b0;
        wait_busy_low(fall);
        chk("frame3_len", 64'(tx_count - base), 64'd8);

        // Reset mid-frame, late tx_done ignored, fresh frame afterwards
        bip_acc = 16'h0102; bip_pc = 11'h003; bip_clk_count = 32'h0405_0607;
        base = tx_count;
        push_frame(64'h0102_0003_0405_0607);
        send_rx(8'h53);
        halt_pulse();
        wait_tx(base + 4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({tx_start, bip_to_uart, bip_enable, busy}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("late_done_ignored_busy", 64'({busy, bip_enable}), 64'd0);
        chk("late_done_no_tx_start", 64'(tx_count - base), 64'd4);
        base = tx_count;
        push_frame(64'h0102_0003_0405_0607);
        send_rx(8'h53);
        halt_pulse();
        wait_busy_low(fall);
        chk("fresh_frame_len", 64'(tx_count - base), 64'd8);
        chk("fresh_frame_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
